// File: rtl/default_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : default_slave_if
//  Description : AXI read/write channel bundle between the crossbar and the
//                default (DECERR) slave. The master modport is the crossbar
//                side; the slave modport is the default slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface default_slave_if #(
    parameter int IDS_BITS  = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4
);
    // Read address channel
    logic [IDS_BITS-1:0]    ARID;
    logic [ADDR_BITS-1:0]   ARADDR;
    logic [LEN_BITS-1:0]    ARLEN;
    logic [2:0]             ARSIZE;
    logic [1:0]             ARBURST;
    logic                   ARVALID;
    logic                   ARREADY;

    // Read data channel
    logic [IDS_BITS-1:0]    RID;
    logic [DATA_BITS-1:0]   RDATA;
    logic [1:0]             RRESP;
    logic                   RLAST;
    logic                   RVALID;
    logic                   RREADY;

    // Write address channel
    logic [IDS_BITS-1:0]    AWID;
    logic [ADDR_BITS-1:0]   AWADDR;
    logic [LEN_BITS-1:0]    AWLEN;
    logic [2:0]             AWSIZE;
    logic [1:0]             AWBURST;
    logic                   AWVALID;
    logic                   AWREADY;

    // Write data channel
    logic [DATA_BITS-1:0]   WDATA;
    logic [DATA_BITS/8-1:0] WSTRB;
    logic                   WLAST;
    logic                   WVALID;
    logic                   WREADY;

    // Write response channel
    logic [IDS_BITS-1:0]    BID;
    logic [1:0]             BRESP;
    logic                   BVALID;
    logic                   BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface
`default_nettype wire

// File: rtl/default_slave.sv
`default_nettype none
// ============================================================================
//  Module      : default_slave
//  Description : AXI default slave. Terminates every read and write whose
//                address maps to no real slave with a DECERR response, so a
//                master never hangs. Read and write engines run independently,
//                one outstanding transaction per direction.
//  Revision    : 1.0 - initial release
// ============================================================================
module default_slave #(
    parameter int IDS_BITS  = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4
) (
    input  logic           clk,
    input  logic           rst,    // synchronous, active-low
    default_slave_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    localparam logic [0:0] c_R_IDLE = 1'b0;
    localparam logic [0:0] c_R_DATA = 1'b1;

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_DATA = 2'd1;
    localparam logic [1:0] c_W_RESP = 2'd2;

    localparam logic [LEN_BITS-1:0] c_CNT_ONE = LEN_BITS'(1);

    // ------------------------------------------------------------------------
    // Read engine signals
    // ------------------------------------------------------------------------
    logic [0:0]          r_rstate;
    logic [0:0]          w_rstate_next;
    logic [IDS_BITS-1:0] r_rid;
    logic [LEN_BITS-1:0] r_len;
    logic [LEN_BITS-1:0] r_cnt;

    logic                w_ar_ready;
    logic                w_r_valid;
    logic                w_r_last;
    logic [1:0]          w_r_resp;
    logic                w_ar_fire;
    logic                w_r_fire;

    // ------------------------------------------------------------------------
    // Write engine signals
    // ------------------------------------------------------------------------
    logic [1:0]          r_wstate;
    logic [1:0]          w_wstate_next;
    logic [IDS_BITS-1:0] r_bid;

    logic                w_aw_ready;
    logic                w_w_ready;
    logic                w_b_valid;
    logic [1:0]          w_b_resp;
    logic                w_aw_fire;
    logic                w_wlast_fire;
    logic                w_b_fire;

    // ------------------------------------------------------------------------
    // Address/data/attribute fields the default slave never looks at. They
    // are collected here so their being unused is explicit.
    // ------------------------------------------------------------------------
    logic [ADDR_BITS-1:0]   w_unused_araddr;
    logic [ADDR_BITS-1:0]   w_unused_awaddr;
    logic [DATA_BITS-1:0]   w_unused_wdata;
    logic [DATA_BITS/8-1:0] w_unused_wstrb;
    logic [LEN_BITS-1:0]    w_unused_awlen;
    logic [9:0]             w_unused_attr;

    assign w_unused_araddr = bus.ARADDR;
    assign w_unused_awaddr = bus.AWADDR;
    assign w_unused_wdata  = bus.WDATA;
    assign w_unused_wstrb  = bus.WSTRB;
    assign w_unused_awlen  = bus.AWLEN;   // WLAST alone ends a write burst
    assign w_unused_attr   = {bus.ARSIZE, bus.ARBURST, bus.AWSIZE, bus.AWBURST};

    // ========================================================================
    // Read engine
    // ========================================================================
    assign w_ar_fire = w_ar_ready & bus.ARVALID;
    assign w_r_fire  = w_r_valid  & bus.RREADY;

    // Read state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rstate <= c_R_IDLE;
        end else begin
            r_rstate <= w_rstate_next;
        end
    end

    // Latch the request ID/length on acceptance and count delivered beats
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rid <= '0;
            r_len <= '0;
            r_cnt <= '0;
        end else if (w_ar_fire) begin
            r_rid <= bus.ARID;
            r_len <= bus.ARLEN;
            r_cnt <= '0;
        end else if (w_r_fire && !w_r_last) begin
            // Never increments past r_len, so a 16-beat burst cannot wrap
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    // Read next-state: leave IDLE on AR acceptance, return after the last beat
    always_comb begin
        w_rstate_next = r_rstate;
        case (r_rstate)
            c_R_IDLE: if (w_ar_fire)             w_rstate_next = c_R_DATA;
            c_R_DATA: if (w_r_fire && w_r_last)  w_rstate_next = c_R_IDLE;
            default:                             w_rstate_next = c_R_IDLE;
        endcase
    end

    // Read outputs decoded from state and latched fields only; ARREADY is
    // additionally held low while reset is asserted
    always_comb begin
        w_ar_ready = 1'b0;
        w_r_valid  = 1'b0;
        w_r_last   = 1'b0;
        w_r_resp   = c_RESP_OKAY;
        case (r_rstate)
            c_R_IDLE: begin
                w_ar_ready = rst;
            end
            c_R_DATA: begin
                w_r_valid = 1'b1;
                w_r_last  = (r_cnt == r_len);
                w_r_resp  = c_RESP_DECERR;
            end
            default: begin
                w_ar_ready = 1'b0;
            end
        endcase
    end

    assign bus.ARREADY = w_ar_ready;
    assign bus.RVALID  = w_r_valid;
    assign bus.RLAST   = w_r_last;
    assign bus.RRESP   = w_r_resp;
    assign bus.RID     = r_rid;
    assign bus.RDATA   = '0;

    // ========================================================================
    // Write engine
    // ========================================================================
    assign w_aw_fire    = w_aw_ready & bus.AWVALID;
    assign w_wlast_fire = w_w_ready  & bus.WVALID & bus.WLAST;
    assign w_b_fire     = w_b_valid  & bus.BREADY;

    // Write state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wstate <= c_W_IDLE;
        end else begin
            r_wstate <= w_wstate_next;
        end
    end

    // Latch the write ID on AW acceptance for echo on the B channel
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bid <= '0;
        end else if (w_aw_fire) begin
            r_bid <= bus.AWID;
        end
    end

    // Write next-state: address, sink data until WLAST, then respond
    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            c_W_IDLE: if (w_aw_fire)    w_wstate_next = c_W_DATA;
            c_W_DATA: if (w_wlast_fire) w_wstate_next = c_W_RESP;
            c_W_RESP: if (w_b_fire)     w_wstate_next = c_W_IDLE;
            default:                    w_wstate_next = c_W_IDLE;
        endcase
    end

    // Write outputs decoded from state; W beats are only taken in W_DATA
    always_comb begin
        w_aw_ready = 1'b0;
        w_w_ready  = 1'b0;
        w_b_valid  = 1'b0;
        w_b_resp   = c_RESP_OKAY;
        case (r_wstate)
            c_W_IDLE: w_aw_ready = rst;
            c_W_DATA: w_w_ready  = 1'b1;
            c_W_RESP: begin
                w_b_valid = 1'b1;
                w_b_resp  = c_RESP_DECERR;
            end
            default:  w_aw_ready = 1'b0;
        endcase
    end

    assign bus.AWREADY = w_aw_ready;
    assign bus.WREADY  = w_w_ready;
    assign bus.BVALID  = w_b_valid;
    assign bus.BRESP   = w_b_resp;
    assign bus.BID     = r_bid;

endmodule
`default_nettype wire

// File: tb/tb_default_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_default_slave
//  Description : Self-checking bench for default_slave: table of read bursts,
//                hand-written write/concurrency/reset sequences, then random
//                traffic compared with a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_default_slave;

    localparam int IDS  = 8;
    localparam int ADDR = 32;
    localparam int DATA = 32;
    localparam int LEN  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    default_slave_if #(.IDS_BITS(IDS), .ADDR_BITS(ADDR), .DATA_BITS(DATA), .LEN_BITS(LEN)) bus ();

    default_slave #(.IDS_BITS(IDS), .ADDR_BITS(ADDR), .DATA_BITS(DATA), .LEN_BITS(LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
        bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0;
    endtask

    // Issue one read and drain it; RREADY optionally toggles 1,0,1,0...
    task automatic read_burst(input string tag, input logic [7:0] id, input logic [3:0] len,
                              input bit toggle, input int exp_beats);
        int   beats = 0;
        int   cyc   = 0;
        bit   done  = 0;
        logic s_valid, s_last;
        logic [7:0] s_id;
        logic [1:0] s_resp;
        bus.ARVALID = 1'b1; bus.ARID = id; bus.ARLEN = len;
        bus.ARADDR = $urandom;
        check({tag, "_arready_pre"}, bus.ARREADY, 1'b1);
        tick();
        bus.ARVALID = 1'b0; bus.ARID = 8'($urandom); bus.ARLEN = 4'($urandom);
        check({tag, "_arready_busy"}, bus.ARREADY, 1'b0);
        check({tag, "_rvalid_first"}, bus.RVALID, 1'b1);
        while (!done && cyc < 100) begin
            bus.RREADY = toggle ? 1'((cyc % 2) == 0) : 1'b1;
            s_valid = bus.RVALID; s_last = bus.RLAST; s_id = bus.RID; s_resp = bus.RRESP;
            if (s_valid && bus.RREADY) begin
                beats++;
                check({tag, "_rlast"}, s_last, 1'(beats == exp_beats));
                check({tag, "_rid"},   s_id,   id);
                check({tag, "_rresp"}, s_resp, 2'b11);
                check({tag, "_rdata"}, bus.RDATA, '0);
                if (s_last) done = 1;
            end
            tick();
            cyc++;
            if (s_valid && !bus.RREADY) begin
                check({tag, "_hold_valid"}, bus.RVALID, 1'b1);
                check({tag, "_hold_rid"},   bus.RID,    s_id);
                check({tag, "_hold_last"},  bus.RLAST,  s_last);
                check({tag, "_hold_resp"},  bus.RRESP,  s_resp);
            end
        end
        bus.RREADY = 1'b0;
        check({tag, "_completed"},   done, 1'b1);
        check({tag, "_beats"},       beats, exp_beats);
        check({tag, "_rvalid_after"}, bus.RVALID, 1'b0);
        check({tag, "_arready_after"}, bus.ARREADY, 1'b1);
    endtask

    // Issue one write of nbeats data beats; BREADY withheld for bready_delay cycles
    task automatic write_burst(input string tag, input logic [7:0] id, input int nbeats,
                               input int bready_delay);
        bus.AWVALID = 1'b1; bus.AWID = id; bus.AWADDR = $urandom;
        check({tag, "_awready_pre"}, bus.AWREADY, 1'b1);
        check({tag, "_wready_idle"}, bus.WREADY, 1'b0);
        tick();
        bus.AWVALID = 1'b0; bus.AWID = 8'($urandom);
        check({tag, "_awready_busy"}, bus.AWREADY, 1'b0);
        for (int b = 0; b < nbeats; b++) begin
            bus.WVALID = 1'b1; bus.WLAST = 1'(b == nbeats - 1);
            bus.WDATA = $urandom; bus.WSTRB = 4'($urandom);
            check({tag, "_wready"}, bus.WREADY, 1'b1);
            check({tag, "_bvalid_early"}, bus.BVALID, 1'b0);
            tick();
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        check({tag, "_bvalid"}, bus.BVALID, 1'b1);
        check({tag, "_bid"},    bus.BID,    id);
        check({tag, "_bresp"},  bus.BRESP,  2'b11);
        check({tag, "_wready_resp"}, bus.WREADY, 1'b0);
        for (int d = 0; d < bready_delay; d++) begin
            tick();
            check({tag, "_bvalid_hold"}, bus.BVALID, 1'b1);
            check({tag, "_bid_hold"},    bus.BID,    id);
            check({tag, "_awready_hold"}, bus.AWREADY, 1'b0);
        end
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        check({tag, "_bvalid_after"}, bus.BVALID, 1'b0);
        check({tag, "_bresp_after"},  bus.BRESP,  2'b00);
        check({tag, "_awready_after"}, bus.AWREADY, 1'b1);
    endtask

    typedef struct {
        logic [7:0] id;
        logic [3:0] len;
        bit         toggle;
        int         exp_beats;
    } rd_vec_t;

    rd_vec_t rv [6];

    // Reference model state for random traffic
    int         m_rd_left;
    logic [7:0] m_rd_id;
    bit         m_w_open, m_w_resp;
    logic [7:0] m_w_id;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rv[0] = '{8'h15, 4'd0,  1'b0, 1};
        rv[1] = '{8'h3A, 4'd3,  1'b1, 4};
        rv[2] = '{8'hC7, 4'd15, 1'b0, 16};
        rv[3] = '{8'h21, 4'd1,  1'b1, 2};
        rv[4] = '{8'h9E, 4'd7,  1'b0, 8};
        rv[5] = '{8'h10, 4'd15, 1'b1, 16};

        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        // Everything quiet in reset
        check("rst_arready", bus.ARREADY, 1'b0);
        check("rst_awready", bus.AWREADY, 1'b0);
        check("rst_rvalid",  bus.RVALID,  1'b0);
        check("rst_wready",  bus.WREADY,  1'b0);
        check("rst_bvalid",  bus.BVALID,  1'b0);
        check("rst_rid",     bus.RID,     8'h00);
        check("rst_bid",     bus.BID,     8'h00);
        check("rst_rresp",   bus.RRESP,   2'b00);
        rst = 1'b1;
        #1;
        check("rel_arready", bus.ARREADY, 1'b1);
        check("rel_awready", bus.AWREADY, 1'b1);
        tick();

        // Table of read bursts
        for (int i = 0; i < 6; i++) begin
            read_burst($sformatf("rd%0d", i), rv[i].id, rv[i].len, rv[i].toggle, rv[i].exp_beats);
            tick();
        end

        // W beats offered while idle must not be taken
        bus.WVALID = 1'b1; bus.WLAST = 1'b1;
        check("widle_wready", bus.WREADY, 1'b0);
        tick();
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        check("widle_bvalid", bus.BVALID, 1'b0);
        check("widle_awready", bus.AWREADY, 1'b1);

        // Writes
        write_burst("wr3", 8'h26, 3, 2);
        write_burst("wr1", 8'h5B, 1, 0);
        write_burst("wr16", 8'hE1, 16, 1);

        // Concurrent AR and AW in the same cycle
        bus.ARVALID = 1'b1; bus.ARID = 8'h11; bus.ARLEN = 4'd1;
        bus.AWVALID = 1'b1; bus.AWID = 8'h22;
        check("conc_arready", bus.ARREADY, 1'b1);
        check("conc_awready", bus.AWREADY, 1'b1);
        tick();
        bus.ARVALID = 1'b0; bus.AWVALID = 1'b0;
        check("conc_rvalid", bus.RVALID, 1'b1);
        check("conc_wready", bus.WREADY, 1'b1);
        check("conc_arbusy", bus.ARREADY, 1'b0);
        check("conc_awbusy", bus.AWREADY, 1'b0);
        bus.RREADY = 1'b1; bus.WVALID = 1'b1; bus.WLAST = 1'b1; bus.BREADY = 1'b1;
        check("conc_rlast0", bus.RLAST, 1'b0);
        tick();
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        check("conc_rlast1", bus.RLAST, 1'b1);
        check("conc_rid",    bus.RID,   8'h11);
        check("conc_bvalid", bus.BVALID, 1'b1);
        check("conc_bid",    bus.BID,   8'h22);
        tick();
        bus.RREADY = 1'b0; bus.BREADY = 1'b0;
        check("conc_rdone",  bus.RVALID, 1'b0);
        check("conc_bdone",  bus.BVALID, 1'b0);
        check("conc_arrdy",  bus.ARREADY, 1'b1);
        check("conc_awrdy",  bus.AWREADY, 1'b1);

        // Reset during beat 2 of an 8-beat burst, with a write in flight too
        bus.ARVALID = 1'b1; bus.ARID = 8'h77; bus.ARLEN = 4'd7;
        bus.AWVALID = 1'b1; bus.AWID = 8'h66;
        tick();
        bus.ARVALID = 1'b0; bus.AWVALID = 1'b0;
        bus.RREADY = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mrst_arready_now", bus.ARREADY, 1'b0);
        check("mrst_awready_now", bus.AWREADY, 1'b0);
        tick();
        bus.RREADY = 1'b0;
        check("mrst_rvalid",  bus.RVALID,  1'b0);
        check("mrst_rlast",   bus.RLAST,   1'b0);
        check("mrst_rresp",   bus.RRESP,   2'b00);
        check("mrst_rid",     bus.RID,     8'h00);
        check("mrst_wready",  bus.WREADY,  1'b0);
        check("mrst_bvalid",  bus.BVALID,  1'b0);
        check("mrst_arready", bus.ARREADY, 1'b0);
        check("mrst_awready", bus.AWREADY, 1'b0);
        rst = 1'b1;
        #1;
        check("mrel_arready", bus.ARREADY, 1'b1);
        check("mrel_awready", bus.AWREADY, 1'b1);
        check("mrel_rvalid",  bus.RVALID,  1'b0);
        tick();
        check("mrel_rvalid2", bus.RVALID,  1'b0);
        read_burst("post_rst", 8'h5C, 4'd2, 1'b0, 3);

        // Random traffic against a transaction-level model
        idle_inputs();
        tick();
        m_rd_left = 0; m_rd_id = '0; m_w_open = 0; m_w_resp = 0; m_w_id = '0;
        for (int c = 0; c < 3000; c++) begin
            check("rnd_arready", bus.ARREADY, 1'(rst && m_rd_left == 0));
            check("rnd_rvalid",  bus.RVALID,  1'(m_rd_left != 0));
            if (m_rd_left != 0) begin
                check("rnd_rlast", bus.RLAST, 1'(m_rd_left == 1));
                check("rnd_rid",   bus.RID,   m_rd_id);
                check("rnd_rresp", bus.RRESP, 2'b11);
            end else begin
                check("rnd_rresp_idle", bus.RRESP, 2'b00);
            end
            check("rnd_awready", bus.AWREADY, 1'(rst && !m_w_open && !m_w_resp));
            check("rnd_wready",  bus.WREADY,  1'(m_w_open));
            check("rnd_bvalid",  bus.BVALID,  1'(m_w_resp));
            if (m_w_resp) begin
                check("rnd_bid",   bus.BID,   m_w_id);
                check("rnd_bresp", bus.BRESP, 2'b11);
            end

            rst         = 1'($urandom_range(0, 63) != 0);
            bus.ARVALID = 1'($urandom);
            bus.ARID    = 8'($urandom);
            bus.ARLEN   = 4'($urandom);
            bus.RREADY  = 1'($urandom);
            bus.AWVALID = 1'($urandom);
            bus.AWID    = 8'($urandom);
            bus.WVALID  = 1'($urandom);
            bus.WLAST   = 1'($urandom_range(0, 3) == 0);
            bus.WDATA   = $urandom;
            bus.BREADY  = 1'($urandom);

            if (!rst) begin
                m_rd_left = 0; m_w_open = 0; m_w_resp = 0;
            end else begin
                if (m_rd_left == 0) begin
                    if (bus.ARVALID) begin
                        m_rd_left = int'(bus.ARLEN) + 1;
                        m_rd_id   = bus.ARID;
                    end
                end else if (bus.RREADY) begin
                    m_rd_left--;
                end
                if (!m_w_open && !m_w_resp) begin
                    if (bus.AWVALID) begin
                        m_w_open = 1;
                        m_w_id   = bus.AWID;
                    end
                end else if (m_w_open) begin
                    if (bus.WVALID && bus.WLAST) begin
                        m_w_open = 0;
                        m_w_resp = 1;
                    end
                end else if (bus.BREADY) begin
                    m_w_resp = 0;
                end
            end
            tick();
        end

        idle_inputs();
        rst = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/default_slave.md
# default_slave

AXI default slave for the bridge: terminates every read and write transaction whose address decodes to no mapped slave. It responds with DECERR so that masters never hang. It sits on the slave side of the crossbar. Its R-channel outputs feed the read-data mux inputs `*_slaveDefault`, and its B-channel outputs feed the write-response mux the same way. It has independent read and write engines.

## Interface
Parameters:
- IDS_BITS, 8, slave-side ID width; bits [5:4] carry the master tag (01 = master0, 10 = master1)
- ADDR_BITS, 32, address width (accepted, ignored)
- DATA_BITS, 32, data width
- LEN_BITS, 4, burst length field width (beats = LEN+1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous and active-low
- ARID  in  IDS_BITS  read request ID
- ARADDR  in  ADDR_BITS  ignored
- ARLEN  in  LEN_BITS  beats−1
- ARSIZE  in  3  ignored
- ARBURST  in  2  ignored
- ARVALID  in  1  read request valid
- ARREADY  out  1  read request accept
- RID  out  IDS_BITS  echo of latched ARID
- RDATA  out  DATA_BITS  always 0
- RRESP  out  2  2'b11 (DECERR) while RVALID, else 0
- RLAST  out  1  final beat
- RVALID  out  1  read data valid
- RREADY  in  1  read data accept
- AWID  in  IDS_BITS  write request ID
- AWADDR  in  ADDR_BITS  ignored
- AWLEN  in  LEN_BITS  ignored (WLAST terminates)
- AWSIZE  in  3  ignored
- AWBURST  in  2  ignored
- AWVALID  in  1  write request valid
- AWREADY  out  1  write request accept
- WDATA  in  DATA_BITS  discarded
- WSTRB  in  DATA_BITS/8  discarded
- WLAST  in  1  last write beat
- WVALID  in  1  write data valid
- WREADY  out  1  write data accept
- BID  out  IDS_BITS  echo of latched AWID
- BRESP  out  2  2'b11 while BVALID, else 0
- BVALID  out  1  write response valid
- BREADY  in  1  write response accept

## Operation
- Read FSM R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY, latch ARID into rid_q and ARLEN into len_q, clear beat counter cnt, go to R_DATA.
  - R_DATA: RVALID=1, RID=rid_q, RDATA=0, RRESP=DECERR, RLAST=(cnt==len_q).
    - On RVALID&RREADY with !RLAST: cnt+1.
    - On RVALID&RREADY with RLAST: go to R_IDLE.
    - Outputs stay stable while RREADY=0.
- Write FSM W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch AWID into bid_q and go to W_DATA.
  - W_DATA: WREADY=1. Every beat is discarded. On WVALID&WLAST, go to W_RESP.
  - W_RESP: BVALID=1, BID=bid_q, BRESP=DECERR. On BREADY, go to W_IDLE.
  - WVALID seen in W_IDLE or W_RESP is not accepted (WREADY=0).
- Read and write engines are fully independent and may be active in the same cycle.
- Only one outstanding transaction per direction; ARREADY/AWREADY stay low until the current one completes.
- Counter cnt is LEN_BITS wide. len_q=15 gives 16 beats with no wrap before RLAST.
- Every output is a function of registered state and latched fields only, with no input→output combinational path. The exception is the rst gating of ARREADY/AWREADY.

## Timing
- Reset: on a rising edge with rst=0, both FSMs go to IDLE and rid_q, bid_q, len_q, cnt clear to 0.
- While rst=0, every output is 0, including ARREADY and AWREADY (both are gated by rst).
- The first cycle with rst=1 has ARREADY=AWREADY=1.
- Reset asserted mid-burst or mid-response aborts immediately: RVALID/BVALID are 0 in the cycle after the reset edge and no partial response resumes.
- Read latency: AR handshake at edge N gives first RVALID in cycle N+1. With RREADY held high, an L+1-beat burst ends at edge N+1+L, and ARREADY=1 again in the following cycle.
- Write: AW handshake at edge N gives WREADY=1 in cycle N+1. WLAST handshake at edge M gives BVALID in cycle M+1. BREADY handshake at edge K gives AWREADY=1 in cycle K+1.
- A single-beat write has a minimum 3 cycles from AW handshake to re-acceptance.

## Test plan
- Reset, then single read: ARID=8'h15, ARLEN=0 → ARREADY=0 and RVALID=1 in the next cycle, RID=8'h15, RDATA=0, RRESP=2'b11, RLAST=1. After the RREADY handshake, ARREADY=1.
- Burst read with backpressure: ARLEN=3, RREADY toggling 1,0,1,0,… → exactly 4 accepted beats, RLAST only on the 4th, all outputs stable across RREADY=0 cycles.
- Write: AWID=8'h26, then 3 W beats with WLAST on the 3rd, BREADY held 0 for 2 cycles → BVALID=1, BID=8'h26, BRESP=2'b11 held until BREADY. Then AWREADY=1.
- Concurrent traffic: AR (ARLEN=1) and AW issued in the same cycle → both accepted in the same cycle, and the R and B responses complete independently and correctly.
- Mid-operation reset: rst=0 during beat 2 of an ARLEN=7 burst → all outputs 0 while rst=0. After release, ARREADY=AWREADY=1, RVALID=0, and a new read starts cleanly.
- Max length: ARLEN=15 with RREADY=1 → 16 beats, RLAST on beat 16 only, no extra beat.
